if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage. Owns the PC and issues one instruction request at a time on the instruction SRAM-style bus (req / addr_ok / data_ok).
- Presents the fetched pc/instruction pair to the IF/ID pipeline register.
- IF/ID captures `if_pc`/`if_inst` on every edge where the global stall is inactive.
- This block therefore raises `stallreq_if` to the pipeline controller until a valid instruction is in hand. It also accepts redirects from the ID stage (branch/jump) and from the exception unit (flush).

Parameters:
- RESET_PC, 32'hBFC00000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- stall  in  1  global stall from controller; same signal IF/ID uses, 1 = stall
- flush  in  1  exception flush, 1 = flush
- flush_pc  in  32  redirect target when flush=1
- branch_flag  in  1  ID-stage taken branch/jump
- branch_target  in  32  target when branch_flag=1
- inst_req  out  1  bus request
- inst_addr  out  32  bus address (= current PC)
- inst_addr_ok  in  1  address accepted this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data
- if_pc  out  32  PC of instruction offered to IF/ID
- if_inst  out  32  instruction offered to IF/ID
- if_excp_adel  out  1  fetch address misaligned (pc[1:0]!=0)
- stallreq_if  out  1  request global stall; instruction not yet available

Behaviour:

Reset (`rst_n`=0 at edge):
- pc=RESET_PC, state=REQ, inst buffer=0, discard flag=0.
- While `rst_n`=0: `inst_req`=0, `stallreq_if`=0, `if_inst`=0, `if_excp_adel`=0, `if_pc`=pc.
- A reset mid-transaction abandons it. The bus is assumed reset in the same cycle.

States:
- REQ: `inst_req`=1, `inst_addr`=pc.
  - `addr_ok`=1 -> WAIT.
  - If pc[1:0]!=0: `inst_req`=0; the instruction is treated as available: `if_inst`=0, `if_excp_adel`=1, `stallreq_if`=0. Handled as in HOLD.
- WAIT: `inst_req`=0; waiting for `data_ok` (earliest the cycle after `addr_ok`).
  - `data_ok`=1 -> instruction available this cycle: `if_inst`=`inst_rdata` (combinational bypass), and the word is written to the buffer.
  - If `stall`=1 -> HOLD; otherwise the word is consumed (see Consume).
- HOLD: `if_inst`=buffer; instruction available; waits for `stall`=0.
- DISCARD: an outstanding read belongs to a squashed PC. `inst_req`=0 and `stallreq_if`=1. On `data_ok` the data is dropped -> REQ at the already-updated pc.

`stallreq_if`:
- 1 in REQ (aligned pc), in WAIT without `data_ok`, and in DISCARD.
- 0 otherwise.

Consume (an edge with `stall`=0 and an instruction available):
- pc <= `branch_flag` ? `branch_target` : pc+PC_STEP (32-bit wrap, carry dropped).
- state <= REQ.
- The ID instruction at that edge is the branch; the consumed word is its delay slot.

Flush (`flush`=1 at edge) has the highest priority, independent of `stall`:
- pc <= `flush_pc`.
- If a read is outstanding at that edge (state WAIT without `data_ok`, or REQ with `addr_ok`=1) -> DISCARD.
- Otherwise (REQ without `addr_ok`, HOLD, WAIT with `data_ok`, misaligned) -> REQ.
- Buffered data is dropped.

Other rules:
- `branch_flag` is ignored on any edge that is not a consume edge.
- A flush in DISCARD updates pc and stays in DISCARD.
- At most one outstanding transaction at any time.
- `if_pc` always equals the pc of the offered instruction.

Test Plan:
- Reset then free-running bus (`addr_ok` in REQ, `data_ok` next cycle, `stall`=0) -> addresses BFC00000, BFC00004, BFC00008 issued; each `if_inst` equals the returned rdata with the matching `if_pc`; `stallreq_if`=0 only in `data_ok` cycles.
- `data_ok` with `stall`=1 held 3 cycles -> state HOLD; `if_pc`/`if_inst` held constant; no new `inst_req`; PC advances by 4 only after `stall` drops.
- Consume edge with `branch_flag`=1, `branch_target`=0x80001000 -> next `inst_addr`=0x80001000. `branch_flag`=1 on a non-consume edge -> ignored.
- `flush`=1, `flush_pc`=0xBFC00380 while in WAIT -> DISCARD; the next `data_ok` word (0xDEADBEEF) never appears on `if_inst`; the next request is to BFC00380.
- `flush` with `flush_pc`=0x80000002 -> no `inst_req`; `if_excp_adel`=1, `if_inst`=0, `stallreq_if`=0, `if_pc`=0x80000002.
- `rst_n`=0 for one cycle during WAIT -> `inst_req`=0 and `stallreq_if`=0 during reset; afterwards a request to BFC00000.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs one-at-a-time reads on the
// req/addr_ok/data_ok instruction bus and offers pc/inst pairs to IF/ID.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_excp_adel,
    output logic        stallreq_if
);

    localparam logic [1:0] S_REQ     = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;

    logic misaligned;
    logic avail;
    logic consume;
    logic outstanding;

    always_comb begin
        misaligned  = (pc_q[1:0] != 2'b00);
        avail       = ((state_q == S_REQ) && misaligned)
                   || ((state_q == S_WAIT) && inst_data_ok)
                   || (state_q == S_HOLD);
        consume     = avail && !stall;
        // A read is still in flight past this edge unless its data arrives now.
        outstanding = ((state_q == S_WAIT) && !inst_data_ok)
                   || ((state_q == S_REQ) && !misaligned && inst_addr_ok)
                   || ((state_q == S_DISCARD) && !inst_data_ok);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        if (flush) begin
            pc_d    = flush_pc;
            buf_d   = '0;
            state_d = outstanding ? S_DISCARD : S_REQ;
        end else begin
            if ((state_q == S_WAIT) && inst_data_ok) begin
                buf_d = inst_rdata;
            end
            if (consume) begin
                pc_d    = branch_flag ? branch_target : (pc_q + 32'(PC_STEP));
                state_d = S_REQ;
            end else begin
                case (state_q)
                    S_REQ: begin
                        if (!misaligned && inst_addr_ok) begin
                            state_d = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (inst_data_ok) begin
                            state_d = S_HOLD;
                        end
                    end
                    S_DISCARD: begin
                        if (inst_data_ok) begin
                            state_d = S_REQ;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        inst_addr    = pc_q;
        if_pc        = pc_q;
        inst_req     = rst_n && (state_q == S_REQ) && !misaligned;
        if_excp_adel = rst_n && (state_q == S_REQ) && misaligned;
        stallreq_if  = rst_n && (((state_q == S_REQ) && !misaligned)
                              || ((state_q == S_WAIT) && !inst_data_ok)
                              || (state_q == S_DISCARD));
        if_inst      = '0;
        if (rst_n) begin
            if ((state_q == S_WAIT) && inst_data_ok) begin
                if_inst = inst_rdata;
            end else if (state_q == S_HOLD) begin
                if_inst = buf_q;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: expected bus addresses and offered
// instructions are queued by the stimulus and popped by a negedge monitor.
module tb_if_fetch;

    localparam logic [31:0] BOGUS_TGT = 32'h0BAD_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_excp_adel;
    logic        stallreq_if;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;

    logic [31:0] addr_q[$];
    exp_t        out_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch #(
        .RESET_PC(32'hBFC0_0000),
        .PC_STEP (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_excp_adel (if_excp_adel),
        .stallreq_if  (stallreq_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: address handshakes and offered instructions at consume edges.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && inst_req && inst_addr_ok) begin
                if (addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: addr %h, expected no request", inst_addr);
                end else begin
                    chk("req_addr", inst_addr, addr_q.pop_front());
                end
            end
            if (rst_n && !stallreq_if && !stall && !flush) begin
                if (out_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_offer: pc %h inst %h, expected no offer", if_pc, if_inst);
                end else begin
                    e = out_q.pop_front();
                    chk("offer_pc", if_pc, e.pc);
                    chk("offer_inst", if_inst, e.inst);
                    chk("offer_adel", 32'(if_excp_adel), 32'(e.adel));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Quiet bus; branch_flag is held high so any non-consume edge tests that it is ignored.
    task automatic idle();
        stall         = 1'b0;
        flush         = 1'b0;
        flush_pc      = '0;
        branch_flag   = 1'b1;
        branch_target = BOGUS_TGT;
        inst_addr_ok  = 1'b0;
        inst_data_ok  = 1'b0;
        inst_rdata    = 32'h5A5A_5A5A;
    endtask

    // Entered in REQ; leaves one cycle after the consume edge, in REQ again.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input int lat, input int nstall,
                         input logic br, input logic [31:0] tgt);
        addr_q.push_back(addr);
        inst_addr_ok = 1'b1;
        #1;
        chk("req_inst_req", 32'(inst_req), 32'd1);
        chk("req_stallreq", 32'(stallreq_if), 32'd1);
        step();
        idle();
        for (int i = 0; i < lat; i++) begin
            #1;
            chk("wait_stallreq", 32'(stallreq_if), 32'd1);
            chk("wait_inst_req", 32'(inst_req), 32'd0);
            step();
        end
        inst_data_ok = 1'b1;
        inst_rdata   = data;
        if (nstall == 0) begin
            branch_flag   = br;
            branch_target = tgt;
            out_q.push_back('{pc: addr, inst: data, adel: 1'b0});
            step();
            idle();
        end else begin
            stall = 1'b1;
            step();
            idle();
            for (int i = 1; i < nstall; i++) begin
                stall = 1'b1;
                #1;
                chk("hold_pc", if_pc, addr);
                chk("hold_inst", if_inst, data);
                chk("hold_inst_req", 32'(inst_req), 32'd0);
                chk("hold_stallreq", 32'(stallreq_if), 32'd0);
                step();
                idle();
            end
            branch_flag   = br;
            branch_target = tgt;
            out_q.push_back('{pc: addr, inst: data, adel: 1'b0});
            step();
            idle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        step();
        chk("rst_pc", if_pc, 32'hBFC0_0000);
        chk("rst_inst_req", 32'(inst_req), 32'd0);
        chk("rst_stallreq", 32'(stallreq_if), 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        chk("rst_adel", 32'(if_excp_adel), 32'd0);
        rst_n = 1'b1;

        // Free-running sequential fetches, then stall hold and branches.
        fetch(32'hBFC0_0000, 32'h1111_1111, 0, 0, 1'b0, 32'h0);
        fetch(32'hBFC0_0004, 32'h2222_2222, 0, 0, 1'b0, 32'h0);
        fetch(32'hBFC0_0008, 32'h3333_3333, 1, 0, 1'b0, 32'h0);
        fetch(32'hBFC0_000C, 32'hAAAA_0001, 0, 3, 1'b0, 32'h0);
        fetch(32'hBFC0_0010, 32'h2222_0002, 0, 0, 1'b1, 32'h8000_1000);
        fetch(32'h8000_1000, 32'h3333_0003, 0, 2, 1'b1, 32'h8000_2000);

        // Flush while in WAIT: the in-flight word must be dropped.
        addr_q.push_back(32'h8000_2000);
        inst_addr_ok = 1'b1;
        step();
        idle();
        flush    = 1'b1;
        flush_pc = 32'hBFC0_0380;
        step();
        idle();
        #1;
        chk("disc_stallreq", 32'(stallreq_if), 32'd1);
        chk("disc_inst_req", 32'(inst_req), 32'd0);
        chk("disc_pc", if_pc, 32'hBFC0_0380);
        step();
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hDEAD_BEEF;
        #1;
        chk("disc_data_stallreq", 32'(stallreq_if), 32'd1);
        step();
        idle();
        fetch(32'hBFC0_0380, 32'h4444_0004, 0, 0, 1'b0, 32'h0);

        // Flush on an accepted address, redirecting to a misaligned PC.
        addr_q.push_back(32'hBFC0_0384);
        inst_addr_ok = 1'b1;
        flush        = 1'b1;
        flush_pc     = 32'h8000_0002;
        step();
        idle();
        #1;
        chk("disc2_stallreq", 32'(stallreq_if), 32'd1);
        chk("disc2_inst_req", 32'(inst_req), 32'd0);
        step();
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hDEAD_BEEF;
        step();
        idle();
        stall = 1'b1;
        #1;
        chk("adel_inst_req", 32'(inst_req), 32'd0);
        chk("adel_flag", 32'(if_excp_adel), 32'd1);
        chk("adel_inst", if_inst, 32'd0);
        chk("adel_stallreq", 32'(stallreq_if), 32'd0);
        chk("adel_pc", if_pc, 32'h8000_0002);
        step();
        idle();
        branch_flag = 1'b0;
        out_q.push_back('{pc: 32'h8000_0002, inst: 32'h0, adel: 1'b1});
        step();
        idle();
        #1;
        chk("adel_next_pc", if_pc, 32'h8000_0006);
        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        step();
        idle();

        // PC wrap past the top of the address space.
        fetch(32'hFFFF_FFFC, 32'h5555_0005, 0, 0, 1'b0, 32'h0);
        fetch(32'h0000_0000, 32'h6666_0006, 1, 1, 1'b0, 32'h0);

        // Reset in the middle of a transaction.
        addr_q.push_back(32'h0000_0004);
        inst_addr_ok = 1'b1;
        step();
        idle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inst_req", 32'(inst_req), 32'd0);
        chk("mid_rst_stallreq", 32'(stallreq_if), 32'd0);
        chk("mid_rst_inst", if_inst, 32'd0);
        step();
        rst_n = 1'b1;
        idle();
        fetch(32'hBFC0_0000, 32'h7777_0007, 0, 0, 1'b0, 32'h0);
        #1;
        chk("final_addr", inst_addr, 32'hBFC0_0004);
        step();

        chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
        chk("out_q_drained", 32'(out_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
